// File: rtl/cgra_route_stage.sv
// Route controller and 2-entry output buffer around the PE operand mux.
// Select changes wait until the buffer drains so beats from two routes never mix in flight.
module cgra_route_stage #(
    parameter int DATA_W = 32,
    parameter int NUM_IN = 5,
    parameter int SEL_W  = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    input  logic [SEL_W-1:0]  cfg_sel,
    output logic              cfg_ready,
    output logic              cfg_err,
    output logic [SEL_W-1:0]  mux_sel,
    input  logic [NUM_IN-1:0] in_valid_vec,
    output logic [NUM_IN-1:0] in_ready_vec,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              route_busy
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W + 1)'(NUM_IN);

    state_t             state_reg, state_next;
    logic [SEL_W-1:0]   mux_sel_reg, mux_sel_next;
    logic [SEL_W-1:0]   pending_reg, pending_next;
    logic               cfg_err_reg, cfg_err_next;
    logic [1:0]         count_reg, count_next;
    logic               wr_ptr_reg, rd_ptr_reg;
    logic [DATA_W-1:0]  mem_reg [2];

    logic in_ready;
    logic push;
    logic pop;
    logic cfg_accept;
    logic sel_illegal;

    // Ready depends only on registered state/count, never on out_ready.
    assign in_ready = rst_n & (state_reg == ST_RUN) & (count_reg != 2'd2);

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_ready
            assign in_ready_vec[gi] = in_ready & (mux_sel_reg == SEL_W'(gi));
        end
    endgenerate

    assign push        = in_valid_vec[mux_sel_reg] & in_ready;
    assign out_valid   = (count_reg != 2'd0);
    assign pop         = out_valid & out_ready;
    assign out_data    = mem_reg[rd_ptr_reg];
    assign cfg_ready   = (state_reg == ST_RUN);
    assign cfg_accept  = cfg_valid & cfg_ready;
    assign sel_illegal = ({1'b0, cfg_sel} >= NUM_IN_W);
    assign cfg_err     = cfg_err_reg;
    assign mux_sel     = mux_sel_reg;
    assign route_busy  = (state_reg != ST_RUN);

    always_comb begin
        state_next   = state_reg;
        mux_sel_next = mux_sel_reg;
        pending_next = pending_reg;
        cfg_err_next = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (cfg_accept) begin
                    if (sel_illegal) begin
                        cfg_err_next = 1'b1;
                    end else if (cfg_sel != mux_sel_reg) begin
                        pending_next = cfg_sel;
                        state_next   = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (count_reg == 2'd0) begin
                    state_next = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                mux_sel_next = pending_reg;
                state_next   = ST_RUN;
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= ST_RUN;
            mux_sel_reg <= '0;
            pending_reg <= '0;
            cfg_err_reg <= 1'b0;
            count_reg   <= 2'd0;
            wr_ptr_reg  <= 1'b0;
            rd_ptr_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            mux_sel_reg <= mux_sel_next;
            pending_reg <= pending_next;
            cfg_err_reg <= cfg_err_next;
            count_reg   <= count_next;
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
        end
    end

    // Storage needs no reset: out_valid masks stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_reg[wr_ptr_reg] <= in_data;
        end
    end

endmodule

// File: tb/tb_cgra_route_stage.sv
// Directed-vector bench for cgra_route_stage: per-cycle table plus hand-written reset sequences.
module tb_cgra_route_stage;

    localparam int DATA_W = 32;
    localparam int NUM_IN = 5;
    localparam int SEL_W  = 3;

    logic              clk;
    logic              rst_n;
    logic              cfg_valid;
    logic [SEL_W-1:0]  cfg_sel;
    logic              cfg_ready;
    logic              cfg_err;
    logic [SEL_W-1:0]  mux_sel;
    logic [NUM_IN-1:0] in_valid_vec;
    logic [NUM_IN-1:0] in_ready_vec;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_ready;
    logic              route_busy;

    cgra_route_stage #(.DATA_W(DATA_W), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_valid    (cfg_valid),
        .cfg_sel      (cfg_sel),
        .cfg_ready    (cfg_ready),
        .cfg_err      (cfg_err),
        .mux_sel      (mux_sel),
        .in_valid_vec (in_valid_vec),
        .in_ready_vec (in_ready_vec),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .route_busy   (route_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic              cv;
        logic [SEL_W-1:0]  cs;
        logic [NUM_IN-1:0] iv;
        logic [DATA_W-1:0] id;
        logic              ordy;
        logic              e_crdy;
        logic              e_err;
        logic [SEL_W-1:0]  e_sel;
        logic [NUM_IN-1:0] e_irv;
        logic              e_ov;
        logic [DATA_W-1:0] e_od;
        logic              e_busy;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt  = 0;
    int   total_cnt = 0;

    task automatic add(input logic cv, input logic [SEL_W-1:0] cs, input logic [NUM_IN-1:0] iv,
                       input logic [DATA_W-1:0] id, input logic ordy,
                       input logic e_crdy, input logic e_err, input logic [SEL_W-1:0] e_sel,
                       input logic [NUM_IN-1:0] e_irv, input logic e_ov,
                       input logic [DATA_W-1:0] e_od, input logic e_busy);
        vec_t v;
        v.cv = cv; v.cs = cs; v.iv = iv; v.id = id; v.ordy = ordy;
        v.e_crdy = e_crdy; v.e_err = e_err; v.e_sel = e_sel; v.e_irv = e_irv;
        v.e_ov = e_ov; v.e_od = e_od; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    // Compares all outputs; out_data only matters while out_valid is expected.
    task automatic check(input string name, input logic e_crdy, input logic e_err,
                         input logic [SEL_W-1:0] e_sel, input logic [NUM_IN-1:0] e_irv,
                         input logic e_ov, input logic [DATA_W-1:0] e_od, input logic e_busy);
        logic [DATA_W+SEL_W+NUM_IN+3:0] got, exp;
        got = {cfg_ready, cfg_err, mux_sel, in_ready_vec, out_valid, route_busy,
               (e_ov ? out_data : {DATA_W{1'b0}})};
        exp = {e_crdy, e_err, e_sel, e_irv, e_ov, e_busy, (e_ov ? e_od : {DATA_W{1'b0}})};
        total_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("ok   %s crdy=%0b err=%0b sel=%0d irv=%b ov=%0b od=%h busy=%0b",
                     name, cfg_ready, cfg_err, mux_sel, in_ready_vec, out_valid, out_data, route_busy);
        end else begin
            $display("FAIL %s got crdy=%0b err=%0b sel=%0d irv=%b ov=%0b od=%h busy=%0b | want crdy=%0b err=%0b sel=%0d irv=%b ov=%0b od=%h busy=%0b",
                     name, cfg_ready, cfg_err, mux_sel, in_ready_vec, out_valid, out_data, route_busy,
                     e_crdy, e_err, e_sel, e_irv, e_ov, e_od, e_busy);
        end
    endtask

    task automatic drive(input logic cv, input logic [SEL_W-1:0] cs, input logic [NUM_IN-1:0] iv,
                         input logic [DATA_W-1:0] id, input logic ordy);
        cfg_valid = cv; cfg_sel = cs; in_valid_vec = iv; in_data = id; out_ready = ordy;
    endtask

    initial begin
        //  cv cs  iv        data          ordy | crdy err sel irv       ov od            busy
        // stream on src0
        add(0, 0, 5'b00001, 32'h1,       1,   1, 0, 0, 5'b00001, 0, 32'h0,       0);
        add(0, 0, 5'b00001, 32'h2,       1,   1, 0, 0, 5'b00001, 1, 32'h1,       0);
        add(0, 0, 5'b00001, 32'h3,       1,   1, 0, 0, 5'b00001, 1, 32'h2,       0);
        add(0, 0, 5'b00000, 32'h0,       1,   1, 0, 0, 5'b00001, 1, 32'h3,       0);
        add(0, 0, 5'b00000, 32'h0,       0,   1, 0, 0, 5'b00001, 0, 32'h0,       0);
        // backpressure: third beat held off until space opens
        add(0, 0, 5'b00001, 32'hA,       0,   1, 0, 0, 5'b00001, 0, 32'h0,       0);
        add(0, 0, 5'b00001, 32'hB,       0,   1, 0, 0, 5'b00001, 1, 32'hA,       0);
        add(0, 0, 5'b00001, 32'hC,       0,   1, 0, 0, 5'b00000, 1, 32'hA,       0);
        add(0, 0, 5'b00001, 32'hC,       1,   1, 0, 0, 5'b00000, 1, 32'hA,       0);
        add(0, 0, 5'b00001, 32'hC,       1,   1, 0, 0, 5'b00001, 1, 32'hB,       0);
        add(0, 0, 5'b00000, 32'h0,       1,   1, 0, 0, 5'b00001, 1, 32'hC,       0);
        add(0, 0, 5'b00000, 32'h0,       0,   1, 0, 0, 5'b00001, 0, 32'h0,       0);
        // route switch 0 -> 3 with two beats buffered
        add(0, 0, 5'b00001, 32'h11,      0,   1, 0, 0, 5'b00001, 0, 32'h0,       0);
        add(0, 0, 5'b00001, 32'h22,      0,   1, 0, 0, 5'b00001, 1, 32'h11,      0);
        add(1, 3, 5'b00000, 32'h0,       0,   1, 0, 0, 5'b00000, 1, 32'h11,      0);
        add(0, 0, 5'b00000, 32'h0,       0,   0, 0, 0, 5'b00000, 1, 32'h11,      1);
        add(0, 0, 5'b00000, 32'h0,       1,   0, 0, 0, 5'b00000, 1, 32'h11,      1);
        add(0, 0, 5'b00000, 32'h0,       1,   0, 0, 0, 5'b00000, 1, 32'h22,      1);
        add(0, 0, 5'b00000, 32'h0,       0,   0, 0, 0, 5'b00000, 0, 32'h0,       1);
        add(0, 0, 5'b00000, 32'h0,       0,   0, 0, 0, 5'b00000, 0, 32'h0,       1);
        add(0, 0, 5'b01000, 32'hDEAD,    0,   1, 0, 3, 5'b01000, 0, 32'h0,       0);
        add(0, 0, 5'b00000, 32'h0,       1,   1, 0, 3, 5'b01000, 1, 32'hDEAD,    0);
        // valid on a non-selected source is ignored
        add(0, 0, 5'b00001, 32'hBAD,     0,   1, 0, 3, 5'b01000, 0, 32'h0,       0);
        add(0, 0, 5'b00000, 32'h0,       0,   1, 0, 3, 5'b01000, 0, 32'h0,       0);
        // illegal select, then no-op select
        add(1, 6, 5'b00000, 32'h0,       0,   1, 0, 3, 5'b01000, 0, 32'h0,       0);
        add(0, 0, 5'b00000, 32'h0,       0,   1, 1, 3, 5'b01000, 0, 32'h0,       0);
        add(1, 3, 5'b00000, 32'h0,       0,   1, 0, 3, 5'b01000, 0, 32'h0,       0);
        add(0, 0, 5'b00000, 32'h0,       0,   1, 0, 3, 5'b01000, 0, 32'h0,       0);
        // switch with empty buffer still costs DRAIN + SWITCH
        add(1, 1, 5'b00000, 32'h0,       0,   1, 0, 3, 5'b01000, 0, 32'h0,       0);
        add(0, 0, 5'b00010, 32'h77,      0,   0, 0, 3, 5'b00000, 0, 32'h0,       1);
        add(0, 0, 5'b00010, 32'h77,      0,   0, 0, 3, 5'b00000, 0, 32'h0,       1);
        add(0, 0, 5'b00010, 32'h77,      0,   1, 0, 1, 5'b00010, 0, 32'h0,       0);
        add(0, 0, 5'b00000, 32'h0,       0,   1, 0, 1, 5'b00010, 1, 32'h77,      0);

        // asynchronous reset before any clock edge
        drive(0, 0, 5'b00000, 32'h0, 0);
        rst_n = 1'b0;
        #3;
        check("reset_async", 1, 0, 0, 5'b00000, 0, 32'h0, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("reset_release", 1, 0, 0, 5'b00001, 0, 32'h0, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            drive(vecs[i].cv, vecs[i].cs, vecs[i].iv, vecs[i].id, vecs[i].ordy);
            #1;
            check($sformatf("vec%0d", i), vecs[i].e_crdy, vecs[i].e_err, vecs[i].e_sel,
                  vecs[i].e_irv, vecs[i].e_ov, vecs[i].e_od, vecs[i].e_busy);
        end

        // reset mid-drain: route is 1 with one buffered beat left from the table
        @(negedge clk);
        drive(1, 4, 5'b00010, 32'h55, 0);
        #1;
        check("drain_accept", 1, 0, 1, 5'b00010, 1, 32'h77, 0);
        @(negedge clk);
        drive(0, 0, 5'b00000, 32'h0, 0);
        #1;
        check("drain_state", 0, 0, 1, 5'b00000, 1, 32'h77, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("drain_reset", 1, 0, 0, 5'b00000, 0, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("drain_release", 1, 0, 0, 5'b00001, 0, 32'h0, 0);
        repeat (3) @(negedge clk);
        #1;
        check("pending_lost", 1, 0, 0, 5'b00001, 0, 32'h0, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
